cheshire_progress_wdt: RTL and testbench

Synthesizable commit-progress watchdog and end-of-computation (EOC) sequencer for hart 0 of the Cheshire SoC. It watches the CVA6 commit port and the EOC scratch register, and flags a hang when the committed PC stops advancing for a programmable number of cycles. It then runs a grace countdown and asserts a stop request. A decoded EOC/exit code always takes precedence over a hang. It sits next to `cheshire_soc` and feeds both the testbench VIP and an optional on-chip debug-halt path.

---
 rtl/cheshire_wdt_pkg.sv | 23 ++
 rtl/cheshire_wdt_cnt.sv | 40 ++++
 rtl/cheshire_progress_wdt.sv | 178 +++++++++++++++++
 tb/tb_cheshire_progress_wdt.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_wdt_pkg.sv
// Shared state encoding and scratch-register layout for the Cheshire
// commit-progress watchdog and its counters.
package cheshire_wdt_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FIRST = 3'd1,
        COUNT      = 3'd2,
        GRACE      = 3'd3,
        STOPPED    = 3'd4,
        DONE       = 3'd5
    } wdt_state_e;

    localparam int unsigned ExitCodeWidth  = 31;
    localparam int unsigned ScratchDoneBit = 0;
    localparam int unsigned ScratchCodeLsb = 1;
    localparam int unsigned ScratchCodeMsb = ScratchCodeLsb + ExitCodeWidth - 1;

    function automatic logic [ExitCodeWidth-1:0] scratch_exit_code(input logic [31:0] scratch);
        return scratch[ScratchCodeMsb:ScratchCodeLsb];
    endfunction

endpackage

// File: rtl/cheshire_wdt_cnt.sv
// Clear/load/up/down counter. Counting up sticks at all-ones and counting
// down sticks at zero, so neither direction can wrap.
module cheshire_wdt_cnt #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             up_i,
    input  logic             down_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    // Priority: clear, then load, then up, then down.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (up_i) begin
            if (cnt_q != '1) cnt_d = cnt_q + Width'(1);
        end else if (down_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - Width'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cheshire_progress_wdt.sv
// Commit-progress watchdog and EOC sequencer for hart 0: trips when the
// committed PC stalls, then counts down a grace period to a stop request.
module cheshire_progress_wdt
    import cheshire_wdt_pkg::*;
#(
    parameter int unsigned PcWidth  = 64,
    parameter int unsigned CntWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_en_i,
    input  logic [CntWidth-1:0]      cfg_limit_i,
    input  logic [CntWidth-1:0]      cfg_grace_i,
    input  logic                     commit_valid_i,
    input  logic [PcWidth-1:0]       commit_pc_i,
    input  logic [31:0]              scratch_q_i,
    input  logic                     kick_i,
    output logic                     hang_o,
    output logic [PcWidth-1:0]       hang_pc_o,
    output logic                     stop_req_o,
    output logic                     eoc_o,
    output logic [ExitCodeWidth-1:0] exit_code_o,
    output logic [2:0]               state_o
);

    wdt_state_e               state_d, state_q;
    logic [CntWidth-1:0]      limit_d, limit_q;
    logic [CntWidth-1:0]      grace_d, grace_q;
    logic [PcWidth-1:0]       last_pc_d, last_pc_q;
    logic [PcWidth-1:0]       hang_pc_d, hang_pc_q;
    logic [ExitCodeWidth-1:0] exit_code_d, exit_code_q;
    logic                     hang_d, hang_q;
    logic                     stop_d, stop_q;
    logic                     eoc_d, eoc_q;

    logic                stall_clr, stall_up;
    logic                grace_clr, grace_load, grace_down;
    logic [CntWidth-1:0] stall_cnt, grace_cnt, stall_next;
    logic                pc_advance, progress, eoc_seen;

    assign pc_advance = commit_valid_i && (commit_pc_i != last_pc_q);
    assign progress   = pc_advance || kick_i;
    assign eoc_seen   = scratch_q_i[ScratchDoneBit];
    // Trip on the value the stall counter is about to take, so the flag lands
    // exactly limit non-progress cycles after the last progress edge.
    assign stall_next = (stall_cnt == '1) ? stall_cnt : stall_cnt + CntWidth'(1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        limit_d     = limit_q;
        grace_d     = grace_q;
        last_pc_d   = last_pc_q;
        hang_pc_d   = hang_pc_q;
        exit_code_d = exit_code_q;
        hang_d      = hang_q;
        stop_d      = stop_q;
        eoc_d       = eoc_q;
        stall_clr   = 1'b0;
        stall_up    = 1'b0;
        grace_clr   = 1'b0;
        grace_load  = 1'b0;
        grace_down  = 1'b0;

        if (!cfg_en_i) begin
            state_d     = IDLE;
            limit_d     = '0;
            grace_d     = '0;
            last_pc_d   = '0;
            hang_pc_d   = '0;
            exit_code_d = '0;
            hang_d      = 1'b0;
            stop_d      = 1'b0;
            eoc_d       = 1'b0;
            stall_clr   = 1'b1;
            grace_clr   = 1'b1;
        end else if (state_q != IDLE && state_q != DONE && eoc_seen) begin
            // EOC outranks trip and grace expiry; hang/stop flags are kept.
            state_d     = DONE;
            eoc_d       = 1'b1;
            exit_code_d = scratch_exit_code(scratch_q_i);
        end else begin
            unique case (state_q)
                IDLE: begin
                    limit_d   = cfg_limit_i;
                    grace_d   = cfg_grace_i;
                    stall_clr = 1'b1;
                    state_d   = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (commit_valid_i) begin
                        last_pc_d = commit_pc_i;
                        stall_clr = 1'b1;
                        state_d   = COUNT;
                    end
                end
                COUNT: begin
                    if (progress) begin
                        stall_clr = 1'b1;
                        if (pc_advance) last_pc_d = commit_pc_i;
                    end else begin
                        stall_up = 1'b1;
                        if (limit_q != '0 && stall_next == limit_q) begin
                            hang_d     = 1'b1;
                            hang_pc_d  = last_pc_q;
                            grace_load = 1'b1;
                            state_d    = GRACE;
                        end
                    end
                end
                GRACE: begin
                    if (grace_cnt == '0) begin
                        stop_d  = 1'b1;
                        state_d = STOPPED;
                    end else begin
                        grace_down = 1'b1;
                    end
                end
                STOPPED, DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    cheshire_wdt_cnt #(.Width(CntWidth)) i_stall_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (stall_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .up_i       (stall_up),
        .down_i     (1'b0),
        .cnt_o      (stall_cnt)
    );

    cheshire_wdt_cnt #(.Width(CntWidth)) i_grace_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (grace_clr),
        .load_i     (grace_load),
        .load_val_i (grace_q),
        .up_i       (1'b0),
        .down_i     (grace_down),
        .cnt_o      (grace_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            limit_q     <= '0;
            grace_q     <= '0;
            last_pc_q   <= '0;
            hang_pc_q   <= '0;
            exit_code_q <= '0;
            hang_q      <= 1'b0;
            stop_q      <= 1'b0;
            eoc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            limit_q     <= limit_d;
            grace_q     <= grace_d;
            last_pc_q   <= last_pc_d;
            hang_pc_q   <= hang_pc_d;
            exit_code_q <= exit_code_d;
            hang_q      <= hang_d;
            stop_q      <= stop_d;
            eoc_q       <= eoc_d;
        end
    end

    assign hang_o      = hang_q;
    assign hang_pc_o   = hang_pc_q;
    assign stop_req_o  = stop_q;
    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_code_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_cheshire_progress_wdt.sv
// Directed self-checking bench for cheshire_progress_wdt; each scenario task
// drives its own stimulus and compares against hand-computed values.
module tb_cheshire_progress_wdt;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_en_i = 1'b0;
    logic [31:0] cfg_limit_i = '0;
    logic [31:0] cfg_grace_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [63:0] commit_pc_i = '0;
    logic [31:0] scratch_q_i = '0;
    logic        kick_i = 1'b0;
    logic        hang_o;
    logic [63:0] hang_pc_o;
    logic        stop_req_o;
    logic        eoc_o;
    logic [30:0] exit_code_o;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    cheshire_progress_wdt #(.PcWidth(64), .CntWidth(32)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cfg_en_i       (cfg_en_i),
        .cfg_limit_i    (cfg_limit_i),
        .cfg_grace_i    (cfg_grace_i),
        .commit_valid_i (commit_valid_i),
        .commit_pc_i    (commit_pc_i),
        .scratch_q_i    (scratch_q_i),
        .kick_i         (kick_i),
        .hang_o         (hang_o),
        .hang_pc_o      (hang_pc_o),
        .stop_req_o     (stop_req_o),
        .eoc_o          (eoc_o),
        .exit_code_o    (exit_code_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic enable(input logic [31:0] lim, input logic [31:0] gr);
        cfg_limit_i = lim;
        cfg_grace_i = gr;
        cfg_en_i    = 1'b1;
        tick();
    endtask

    task automatic disable_wdt();
        cfg_en_i       = 1'b0;
        scratch_q_i    = '0;
        kick_i         = 1'b0;
        commit_valid_i = 1'b0;
        tick();
    endtask

    task automatic commit(input logic [63:0] pc);
        commit_valid_i = 1'b1;
        commit_pc_i    = pc;
        tick();
        commit_valid_i = 1'b0;
    endtask

    // Ticks until hang_o (which=0) or stop_req_o (which=1) is high; n is the tick count.
    task automatic wait_rise(input int which, input int budget, output int n);
        n = 0;
        while (n < budget && !((which == 0) ? hang_o : stop_req_o)) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++;
        if ({hang_o, stop_req_o, eoc_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {hang_o, stop_req_o, eoc_o}); end
        checks++;
        if (hang_pc_o !== 64'h0 || exit_code_o !== 31'h0) begin errors++; $display("FAIL reset_data: got pc %h code %h expected 0", hang_pc_o, exit_code_o); end
        tick();
        rst_ni = 1'b1;
        scratch_q_i = 32'h1;
        tick();
        checks++;
        if (state_o !== 3'd0 || eoc_o !== 1'b0) begin errors++; $display("FAIL idle_ignores_eoc: got state %0d eoc %b expected 0 0", state_o, eoc_o); end
        scratch_q_i = '0;
    endtask

    task automatic test_normal_eoc();
        enable(32'd100, 32'd10);
        checks++;
        if (state_o !== 3'd1) begin errors++; $display("FAIL normal_wait_first: got %0d expected 1", state_o); end
        for (int i = 0; i < 200; i++) begin
            commit(64'h1000 + 64'(8 * i));
            repeat (4) tick();
        end
        checks++;
        if (hang_o !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL normal_no_trip: got hang %b state %0d expected 0 2", hang_o, state_o); end
        scratch_q_i = 32'h0000_0001;
        tick();
        checks++;
        if (state_o !== 3'd5) begin errors++; $display("FAIL normal_done_state: got %0d expected 5", state_o); end
        checks++;
        if (eoc_o !== 1'b1 || exit_code_o !== 31'd0 || hang_o !== 1'b0) begin errors++; $display("FAIL normal_eoc: got eoc %b code %0d hang %b expected 1 0 0", eoc_o, exit_code_o, hang_o); end
        disable_wdt();
        checks++;
        if (state_o !== 3'd0 || eoc_o !== 1'b0) begin errors++; $display("FAIL normal_disable: got state %0d eoc %b expected 0 0", state_o, eoc_o); end
    endtask

    task automatic test_hang();
        int n;
        enable(32'd10000, 32'd100);
        commit(64'h8000_0000);
        commit(64'h8000_1234);
        wait_rise(0, 10010, n);
        checks++;
        if (n !== 10000) begin errors++; $display("FAIL hang_latency: got %0d expected 10000", n); end
        checks++;
        if (hang_pc_o !== 64'h8000_1234) begin errors++; $display("FAIL hang_pc: got %h expected 8000_1234", hang_pc_o); end
        checks++;
        if (state_o !== 3'd3 || stop_req_o !== 1'b0) begin errors++; $display("FAIL hang_grace: got state %0d stop %b expected 3 0", state_o, stop_req_o); end
        wait_rise(1, 110, n);
        checks++;
        if (n !== 101) begin errors++; $display("FAIL stop_latency: got %0d expected 101", n); end
        checks++;
        if (state_o !== 3'd4 || hang_o !== 1'b1) begin errors++; $display("FAIL stopped_state: got state %0d hang %b expected 4 1", state_o, hang_o); end
        disable_wdt();
        checks++;
        if ({hang_o, stop_req_o, eoc_o} !== 3'b000 || hang_pc_o !== 64'h0) begin errors++; $display("FAIL hang_disable: got flags %b pc %h expected 000 0", {hang_o, stop_req_o, eoc_o}, hang_pc_o); end
    endtask

    task automatic test_eoc_in_grace();
        int n;
        logic stop_seen;
        enable(32'd10000, 32'd100);
        commit(64'h2000);
        commit(64'h8000_1234);
        wait_rise(0, 10010, n);
        checks++;
        if (n !== 10000) begin errors++; $display("FAIL grace_eoc_trip: got %0d expected 10000", n); end
        repeat (49) tick();
        scratch_q_i = 32'h0000_0007;
        tick();
        checks++;
        if (state_o !== 3'd5 || eoc_o !== 1'b1) begin errors++; $display("FAIL grace_eoc_done: got state %0d eoc %b expected 5 1", state_o, eoc_o); end
        checks++;
        if (exit_code_o !== 31'd3) begin errors++; $display("FAIL grace_eoc_code: got %0d expected 3", exit_code_o); end
        scratch_q_i = '0;
        stop_seen = stop_req_o;
        repeat (120) begin
            tick();
            if (stop_req_o) stop_seen = 1'b1;
        end
        checks++;
        if (stop_seen !== 1'b0 || state_o !== 3'd5) begin errors++; $display("FAIL grace_eoc_no_stop: got stop %b state %0d expected 0 5", stop_seen, state_o); end
        disable_wdt();
    endtask

    task automatic test_trip_and_eoc();
        enable(32'd20, 32'd10);
        commit(64'h300);
        repeat (19) tick();
        checks++;
        if (state_o !== 3'd2 || hang_o !== 1'b0) begin errors++; $display("FAIL simul_pre: got state %0d hang %b expected 2 0", state_o, hang_o); end
        scratch_q_i = 32'h0000_0001;
        tick();
        checks++;
        if (state_o !== 3'd5 || hang_o !== 1'b0 || eoc_o !== 1'b1) begin errors++; $display("FAIL simul_eoc_wins: got state %0d hang %b eoc %b expected 5 0 1", state_o, hang_o, eoc_o); end
        disable_wdt();
    endtask

    task automatic test_kick();
        int n;
        logic hang_seen;
        enable(32'd20, 32'd5);
        cfg_limit_i = 32'd5;
        commit(64'h40);
        hang_seen = 1'b0;
        for (int i = 0; i < 195; i++) begin
            kick_i = (i % 15 == 14);
            if (i == 104) begin
                commit_valid_i = 1'b1;
                commit_pc_i    = 64'h44;
            end
            tick();
            kick_i         = 1'b0;
            commit_valid_i = 1'b0;
            if (hang_o) hang_seen = 1'b1;
        end
        checks++;
        if (hang_seen !== 1'b0) begin errors++; $display("FAIL kick_no_trip: got hang %b expected 0", hang_seen); end
        wait_rise(0, 30, n);
        checks++;
        if (n !== 20) begin errors++; $display("FAIL kick_trip_latency: got %0d expected 20", n); end
        checks++;
        if (hang_pc_o !== 64'h44) begin errors++; $display("FAIL kick_hang_pc: got %h expected 44", hang_pc_o); end
        repeat (2) tick();
        checks++;
        if (state_o !== 3'd3) begin errors++; $display("FAIL kick_in_grace: got %0d expected 3", state_o); end
        cfg_en_i = 1'b0;
        tick();
        checks++;
        if (state_o !== 3'd0 || {hang_o, stop_req_o, eoc_o} !== 3'b000 || hang_pc_o !== 64'h0) begin errors++; $display("FAIL disable_in_grace: got state %0d flags %b pc %h expected 0 000 0", state_o, {hang_o, stop_req_o, eoc_o}, hang_pc_o); end
    endtask

    task automatic test_grace_zero();
        int n;
        enable(32'd3, 32'd0);
        commit(64'h100);
        wait_rise(0, 10, n);
        checks++;
        if (n !== 3 || hang_pc_o !== 64'h100) begin errors++; $display("FAIL gz_trip: got n %0d pc %h expected 3 100", n, hang_pc_o); end
        tick();
        checks++;
        if (stop_req_o !== 1'b1 || state_o !== 3'd4) begin errors++; $display("FAIL gz_stop: got stop %b state %0d expected 1 4", stop_req_o, state_o); end
        scratch_q_i = 32'h0000_000B;
        tick();
        checks++;
        if (state_o !== 3'd5 || eoc_o !== 1'b1 || exit_code_o !== 31'd5) begin errors++; $display("FAIL gz_eoc: got state %0d eoc %b code %0d expected 5 1 5", state_o, eoc_o, exit_code_o); end
        checks++;
        if (stop_req_o !== 1'b1 || hang_o !== 1'b1) begin errors++; $display("FAIL gz_sticky_flags: got stop %b hang %b expected 1 1", stop_req_o, hang_o); end
        scratch_q_i = '0;
        tick();
        checks++;
        if (state_o !== 3'd5) begin errors++; $display("FAIL gz_done_sticky: got %0d expected 5", state_o); end
        disable_wdt();
    endtask

    task automatic test_reset_and_limit_zero();
        logic hang_seen;
        enable(32'd50, 32'd5);
        commit(64'h500);
        repeat (10) tick();
        checks++;
        if (state_o !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", state_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (state_o !== 3'd0) begin errors++; $display("FAIL async_reset: got %0d expected 0", state_o); end
        cfg_en_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        enable(32'd0, 32'd0);
        commit(64'h600);
        hang_seen = 1'b0;
        repeat (300) begin
            tick();
            if (hang_o) hang_seen = 1'b1;
        end
        checks++;
        if (hang_seen !== 1'b0 || state_o !== 3'd2) begin errors++; $display("FAIL limit_zero: got hang %b state %0d expected 0 2", hang_seen, state_o); end
        disable_wdt();
    endtask

    initial begin
        test_reset();
        test_normal_eoc();
        test_hang();
        test_eoc_in_grace();
        test_trip_and_eoc();
        test_kick();
        test_grace_zero();
        test_reset_and_limit_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
